// File: rtl/scalar_register_file_mp.sv
// scalar_register_file_mp: multi-port scalar register file for decode.
//   Register 0 is hardwired to zero. Reads are combinational and bypass
//   same-cycle writes; the higher-index write port wins on collisions.
//   Optional RAW scoreboard, built only when RF_SCOREBOARD_EN is defined.
//   Without it, rd_busy is tied to 0, rf_idle is tied to 1, and the
//   reserve inputs are ignored.
//
// Ports (per-port vectors are flattened, port i at [i*W +: W]):
//   clk, rst_n            clock, async active-low reset
//   rd_addr  [NUM_READ*AW]       read addresses
//   rd_data  [NUM_READ*WIDTH]    read data (combinational)
//   rd_busy  [NUM_READ]          addressed register awaits a producer (comb)
//   wr_en    [NUM_WRITE]         write enables
//   wr_addr  [NUM_WRITE*AW]      write addresses
//   wr_data  [NUM_WRITE*WIDTH]   write data
//   rsv_en, rsv_addr [AW]        mark a register busy
//   rf_idle                      no register is busy (from state only)
module scalar_register_file_mp #(
  parameter int unsigned WIDTH     = 36,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned NUM_WRITE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_READ*$clog2(DEPTH)-1:0]  rd_addr,
  output logic [NUM_READ*WIDTH-1:0]          rd_data,
  output logic [NUM_READ-1:0]                rd_busy,
  input  logic [NUM_WRITE-1:0]               wr_en,
  input  logic [NUM_WRITE*$clog2(DEPTH)-1:0] wr_addr,
  input  logic [NUM_WRITE*WIDTH-1:0]         wr_data,
  input  logic                               rsv_en,
  input  logic [$clog2(DEPTH)-1:0]           rsv_addr,
  output logic                               rf_idle
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  // Storage: later ports override earlier ones; address 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(DEPTH); r++) mem[r] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_WRITE); k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
          mem[wr_addr[k*AW +: AW]] <= wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Per read port: zero register, then write-through bypass, then storage.
  for (genvar i = 0; i < int'(NUM_READ); i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] data_c;
    logic             hit_c;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      data_c = mem[ra];
      hit_c  = 1'b0;
      for (int k = 0; k < int'(NUM_WRITE); k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == ra)) begin
          data_c = wr_data[k*WIDTH +: WIDTH];
          hit_c  = 1'b1;
        end
      end
      if (ra == '0) begin
        data_c = '0;
        hit_c  = 1'b0;
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = data_c;
    // A same-cycle write makes the value valid through bypass.
    assign rd_busy[i] = busy[ra] & ~hit_c;
  end

`ifdef RF_SCOREBOARD_EN
  // Scoreboard: writes clear first, then a reserve sets (new producer wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_WRITE); k++) begin
        if (wr_en[k]) busy[wr_addr[k*AW +: AW]] <= 1'b0;
      end
      if (rsv_en && (rsv_addr != '0)) busy[rsv_addr] <= 1'b1;
    end
  end

  assign rf_idle = ~|busy;
`else
  logic unused_rsv;

  assign busy       = '0;
  assign rf_idle    = 1'b1;
  assign unused_rsv = ^{rsv_en, rsv_addr};
`endif

endmodule

// File: tb/tb_scalar_register_file_mp.sv
module tb_scalar_register_file_mp;

  localparam int unsigned WIDTH     = 36;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned NUM_READ  = 2;
  localparam int unsigned NUM_WRITE = 2;
  localparam int unsigned AW        = 5;

`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_READ*AW-1:0]     rd_addr;
  logic [NUM_READ*WIDTH-1:0]  rd_data;
  logic [NUM_READ-1:0]        rd_busy;
  logic [NUM_WRITE-1:0]       wr_en;
  logic [NUM_WRITE*AW-1:0]    wr_addr;
  logic [NUM_WRITE*WIDTH-1:0] wr_data;
  logic                       rsv_en;
  logic [AW-1:0]              rsv_addr;
  logic                       rf_idle;

  scalar_register_file_mp #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_READ(NUM_READ), .NUM_WRITE(NUM_WRITE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rf_idle(rf_idle)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register contents and producer flags.
  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_busy [DEPTH];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit written_now(input int a);
    bit h;
    h = 1'b0;
    for (int k = 0; k < int'(NUM_WRITE); k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input int a);
    logic [WIDTH-1:0] v;
    if (a == 0) return '0;
    v = m_mem[a];
    for (int k = 0; k < int'(NUM_WRITE); k++)
      if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) v = wr_data[k*WIDTH +: WIDTH];
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    return SB && (a != 0) && m_busy[a] && !written_now(a);
  endfunction

  function automatic bit exp_idle();
    if (!SB) return 1'b1;
    for (int r = 0; r < int'(DEPTH); r++) if (m_busy[r]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < int'(DEPTH); r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int p, input int a, input logic [WIDTH-1:0] d);
    wr_en[p]                  = 1'b1;
    wr_addr[p*AW +: AW]       = AW'(a);
    wr_data[p*WIDTH +: WIDTH] = d;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic check_all(input string tag);
    int a;
    #1;
    for (int i = 0; i < int'(NUM_READ); i++) begin
      a = int'(rd_addr[i*AW +: AW]);
      check_val($sformatf("%s_rd%0d_data", tag, i), 64'(rd_data[i*WIDTH +: WIDTH]), 64'(exp_rd(a)));
      check_val($sformatf("%s_rd%0d_busy", tag, i), 64'(rd_busy[i]), 64'(exp_busy(a)));
    end
    check_val({tag, "_idle"}, 64'(rf_idle), 64'(exp_idle()));
  endtask

  // Advance one clock edge and apply the inputs seen at that edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < int'(NUM_WRITE); k++) begin
        if (wr_en[k]) begin
          if (wr_addr[k*AW +: AW] != '0) m_mem[int'(wr_addr[k*AW +: AW])] = wr_data[k*WIDTH +: WIDTH];
          m_busy[int'(wr_addr[k*AW +: AW])] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != '0) m_busy[int'(rsv_addr)] = 1'b1;
    end
    #1;
  endtask

  task automatic rand_inputs();
    clear_inputs();
    for (int i = 0; i < int'(NUM_READ); i++)
      set_rd(i, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31)));
    for (int k = 0; k < int'(NUM_WRITE); k++)
      if ($urandom_range(0, 2) != 0)
        set_wr(k, ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31)),
               WIDTH'({$urandom(), $urandom()}));
    rsv_en   = ($urandom_range(0, 3) == 0);
    rsv_addr = AW'($urandom_range(0, 7));
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    clear_inputs();
    model_reset();

    // Reset state
    #2;
    set_rd(0, 5);
    set_rd(1, 31);
    check_all("reset");
    check_val("reset_idle_const", 64'(rf_idle), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write r5, bypass then storage; unwritten register reads 0
    set_wr(0, 5, 36'h123456789);
    set_rd(0, 5);
    set_rd(1, 6);
    check_all("wr_bypass");
    check_val("wr_bypass_const", 64'(rd_data[0 +: WIDTH]), 64'h123456789);
    tick();
    clear_inputs();
    check_all("wr_store");
    check_val("wr_store_const", 64'(rd_data[0 +: WIDTH]), 64'h123456789);
    check_val("unwritten_const", 64'(rd_data[WIDTH +: WIDTH]), 64'h0);

    // Zero register: writes and reserve to r0 are discarded
    set_wr(0, 0, 36'hFFFFFFFFF);
    set_wr(1, 0, 36'hFFFFFFFFF);
    rsv_en = 1'b1;
    set_rd(0, 0);
    set_rd(1, 0);
    check_all("r0_same");
    check_val("r0_same_const", 64'(rd_data[WIDTH +: WIDTH]), 64'h0);
    tick();
    clear_inputs();
    check_all("r0_next");
    check_val("r0_busy_const", 64'(rd_busy), 64'h0);

    // Write-port collision: higher port wins
    set_wr(0, 7, 36'hAAA);
    set_wr(1, 7, 36'hBBB);
    set_rd(0, 7);
    set_rd(1, 7);
    check_all("coll_same");
    check_val("coll_same_const", 64'(rd_data[0 +: WIDTH]), 64'hBBB);
    tick();
    clear_inputs();
    check_all("coll_next");
    check_val("coll_next_const", 64'(rd_data[WIDTH +: WIDTH]), 64'hBBB);

    // Scoreboard lifecycle on r3
    rsv_en   = 1'b1;
    rsv_addr = AW'(3);
    set_rd(0, 3);
    set_rd(1, 9);
    tick();
    clear_inputs();
    check_all("sb_c1");
    check_val("sb_c1_busy_const", 64'(rd_busy[0]), 64'(SB));
    check_val("sb_c1_idle_const", 64'(rf_idle), 64'(!SB));
    tick();
    tick();
    tick();
    set_wr(1, 3, 36'h42);
    check_all("sb_c4");
    check_val("sb_c4_busy_const", 64'(rd_busy[0]), 64'h0);
    check_val("sb_c4_data_const", 64'(rd_data[0 +: WIDTH]), 64'h42);
    tick();
    clear_inputs();
    check_all("sb_c5");
    check_val("sb_c5_idle_const", 64'(rf_idle), 64'h1);

    // Reserve and write the same register in one cycle
    rsv_en   = 1'b1;
    rsv_addr = AW'(9);
    set_wr(0, 9, 36'h9_0000_0009);
    set_rd(1, 9);
    check_all("rsvwr_same");
    check_val("rsvwr_same_busy_const", 64'(rd_busy[1]), 64'h0);
    tick();
    clear_inputs();
    check_all("rsvwr_next");
    check_val("rsvwr_next_busy_const", 64'(rd_busy[1]), 64'(SB));

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      check_all($sformatf("rnd%0d", c));
      tick();
    end

    // Fill r1-r31, reserve several, then async reset between edges
    for (int a = 1; a < 32; a += 2) begin
      clear_inputs();
      set_wr(0, a, WIDTH'({$urandom(), $urandom()}));
      if (a + 1 < 32) set_wr(1, a + 1, WIDTH'({$urandom(), $urandom()}));
      tick();
    end
    for (int a = 4; a < 20; a += 5) begin
      clear_inputs();
      rsv_en   = 1'b1;
      rsv_addr = AW'(a);
      tick();
    end
    clear_inputs();
    set_rd(0, 4);
    set_rd(1, 17);
    check_all("pre_rst");
    #1;
    rst_n = 1'b0;
    model_reset();
    check_all("async_rst");
    check_val("async_rst_data_const", 64'(rd_data[0 +: WIDTH]), 64'h0);
    check_val("async_rst_busy_const", 64'(rd_busy), 64'h0);
    check_val("async_rst_idle_const", 64'(rf_idle), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < 150; c++) begin
      rand_inputs();
      check_all($sformatf("post%0d", c));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
